// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and constants for the IF->ID pipeline register
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Default-width view of one fetch payload; the RTL itself uses XLEN/ILEN-wide fields
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg : one {pc, pc4, instr} payload register with load enable
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(RV_NOP)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] d_pc,
  input  logic [XLEN-1:0] d_pc4,
  input  logic [ILEN-1:0] d_instr,
  output logic [XLEN-1:0] q_pc,
  output logic [XLEN-1:0] q_pc4,
  output logic [ILEN-1:0] q_instr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_pc    <= '0;
      q_pc4   <= '0;
      q_instr <= NOP_INSTR;
    end else if (load) begin
      q_pc    <= d_pc;
      q_pc4   <= d_pc4;
      q_instr <= d_instr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage_pipe_reg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pipe_reg : IF->ID pipeline register, valid/ready, optional skid
// Optional macro FETCH_PIPE_PERF_EN adds saturating stall/flush counters.
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage_pipe_reg
  import pipe_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter int              SKID      = 1,
  parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(RV_NOP)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [ILEN-1:0] in_instr,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic [ILEN-1:0] out_instr
`ifdef FETCH_PIPE_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  skid_state_t     state;
  skid_state_t     state_next;
  logic            accept;
  logic            drain;
  logic            head_load;
  logic [XLEN-1:0] head_d_pc;
  logic [XLEN-1:0] head_d_pc4;
  logic [ILEN-1:0] head_d_instr;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_pc4;
  logic [ILEN-1:0] head_instr;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready & ~stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  pipe_entry_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP_INSTR)) u_head (
    .clk     (clk),
    .reset   (reset),
    .load    (head_load),
    .d_pc    (head_d_pc),
    .d_pc4   (head_d_pc4),
    .d_instr (head_d_instr),
    .q_pc    (head_pc),
    .q_pc4   (head_pc4),
    .q_instr (head_instr)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic            skid_load;
      logic            head_from_skid;
      logic [XLEN-1:0] skid_pc;
      logic [XLEN-1:0] skid_pc4;
      logic [ILEN-1:0] skid_instr;

      pipe_entry_reg #(.XLEN(XLEN), .ILEN(ILEN), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .load    (skid_load),
        .d_pc    (in_pc),
        .d_pc4   (in_pc4),
        .d_instr (in_instr),
        .q_pc    (skid_pc),
        .q_pc4   (skid_pc4),
        .q_instr (skid_instr)
      );

      // Derived from the state register only, so in_ready is registered
      assign in_ready = (state != TWO);

      assign head_d_pc    = head_from_skid ? skid_pc    : in_pc;
      assign head_d_pc4   = head_from_skid ? skid_pc4   : in_pc4;
      assign head_d_instr = head_from_skid ? skid_instr : in_instr;

      always_comb begin
        state_next     = state;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
          state_next = EMPTY;
        end else begin
          case (state)
            EMPTY: begin
              if (accept) begin
                head_load  = 1'b1;
                state_next = ONE;
              end
            end
            ONE: begin
              if (accept && drain) begin
                head_load = 1'b1;
              end else if (accept) begin
                skid_load  = 1'b1;
                state_next = TWO;
              end else if (drain) begin
                state_next = EMPTY;
              end
            end
            TWO: begin
              if (drain) begin
                head_load      = 1'b1;
                head_from_skid = 1'b1;
                state_next     = ONE;
              end
            end
            default: state_next = EMPTY;
          endcase
        end
      end
    end else begin : g_single
      assign in_ready     = ~out_valid | (out_ready & ~stall);
      assign head_d_pc    = in_pc;
      assign head_d_pc4   = in_pc4;
      assign head_d_instr = in_instr;

      always_comb begin
        state_next = state;
        head_load  = 1'b0;
        if (flush) begin
          state_next = EMPTY;
        end else if (accept) begin
          head_load  = 1'b1;
          state_next = ONE;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
    end
  endgenerate

  // Bubble presentation: downstream sees a clean NOP whenever nothing is valid
  assign out_pc    = out_valid ? head_pc    : '0;
  assign out_pc4   = out_valid ? head_pc4   : '0;
  assign out_instr = out_valid ? head_instr : NOP_INSTR;

`ifdef FETCH_PIPE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (out_valid && stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (out_valid && flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage_pipe_reg : directed vector bench for fetch_stage_pipe_reg
// Revision                : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_pc4;
  logic [31:0] in_instr;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
`ifdef FETCH_PIPE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_stage_pipe_reg #(.XLEN(32), .ILEN(32), .SKID(1), .NOP_INSTR(32'h0000_0013)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_pc4    (in_pc4),
    .in_instr  (in_instr),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_instr (out_instr)
`ifdef FETCH_PIPE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [31:0] pc;
    logic        stall;
    logic        ordy;
    logic        flush;
    logic        ev;
    logic [31:0] epc;
    logic        erdy;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction word is derived from the PC so payload mix-ups show up
  task automatic drive(input logic iv, input logic [31:0] pc, input logic st,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_pc4    = pc + 32'd4;
    in_instr  = 32'hA000_0000 | pc;
    stall     = st;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc, input logic erdy);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
    chk({tag, ".out_pc"},    out_pc,    ev ? epc : 32'd0);
    chk({tag, ".out_pc4"},   out_pc4,   ev ? epc + 32'd4 : 32'd0);
    chk({tag, ".out_instr"}, out_instr, ev ? (32'hA000_0000 | epc) : 32'h0000_0013);
    chk({tag, ".in_ready"},  {31'd0, in_ready}, {31'd0, erdy});
  endtask

  initial begin
    //           iv  pc       st  ord fl   ev  epc      erdy
    vecs[0]  = '{1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b1};
    vecs[1]  = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1};
    vecs[2]  = '{1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1};
    vecs[3]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[4]  = '{1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1};
    vecs[5]  = '{1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0};
    vecs[6]  = '{1'b1, 32'h18, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0};
    vecs[7]  = '{1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1};
    vecs[8]  = '{1'b1, 32'h18, 1'b0, 1'b1, 1'b0, 1'b1, 32'h18, 1'b1};
    vecs[9]  = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[10] = '{1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 1'b1};
    vecs[11] = '{1'b1, 32'h34, 1'b1, 1'b1, 1'b0, 1'b1, 32'h30, 1'b0};
    vecs[12] = '{1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[14] = '{1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1};
    vecs[15] = '{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1};
    vecs[16] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};
    vecs[17] = '{1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 1'b1};
    vecs[18] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 1'b1};
    vecs[19] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_pc4    = '0;
    in_instr  = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].iv, vecs[i].pc, vecs[i].stall, vecs[i].ordy, vecs[i].flush);
      chk_out($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].erdy);
    end

    // Fill both slots, then reset asynchronously between clock edges
    drive(1'b1, 32'h60, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'h64, 1'b1, 1'b1, 1'b0);
    chk_out("two_full", 1'b1, 32'h60, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("async_reset", 1'b0, 32'h0, 1'b1);
    in_valid = 1'b0;
    stall    = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_out("post_reset", 1'b0, 32'h0, 1'b1);

`ifdef FETCH_PIPE_PERF_EN
    drive(1'b1, 32'h70, 1'b0, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h74, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd5);
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
